// File: rtl/thread_sequencer.sv
// thread_sequencer: control stage that runs one thread through the execute stage for PROG_LEN instructions
// Ports:
//   clk, rst_n                    clock (rising edge) and asynchronous active-low reset
//   in_valid/in_ready/in_thread   upstream thread intake handshake
//   exe_thread/exe_instruction    thread and PC issued to the execute stage
//   exe_thread_ret/_instruction_ret  results returned by the execute stage
//   out_valid/out_ready/out_thread   downstream finished-thread handshake
//   busy                          high whenever a thread is held
//   done_count                    completed output handshakes (wraps)
//   cycle_count                   cycles spent on the current thread; exists only when
//                                 SEQ_CYCLE_COUNT_EN is defined
package my_pkg;
    typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_NOP} op_type;
    typedef struct packed {
        op_type     op;
        logic [2:0] dst;
        logic [2:0] src_a;
        logic [2:0] src_b;
    } instr_type;
    typedef struct packed {
        instr_type [7:0]  code;
        logic [7:0][15:0] d;
    } thread_type;
endpackage

module thread_sequencer #(
    parameter int PROG_LEN   = 8,
    parameter int DONE_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  my_pkg::thread_type    in_thread,
    output my_pkg::thread_type    exe_thread,
    output logic [7:0]            exe_instruction,
    input  my_pkg::thread_type    exe_thread_ret,
    input  logic [7:0]            exe_instruction_ret,
    output logic                  out_valid,
    input  logic                  out_ready,
    output my_pkg::thread_type    out_thread,
    output logic                  busy,
    output logic [DONE_CNT_W-1:0] done_count
`ifdef SEQ_CYCLE_COUNT_EN
    ,
    output logic [15:0]           cycle_count
`endif
);
    // PROG_LEN=256 truncates to 0, which is exactly where the 8-bit PC lands after wrapping
    localparam logic [7:0] LAST_PC = 8'(PROG_LEN);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_type;
    state_type          state, state_nx;
    my_pkg::thread_type thr;
    logic [7:0]         pc;
    logic               accept, handoff;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid) state_nx = ISSUE;
            ISSUE:   state_nx = WAIT;
            WAIT:    state_nx = (exe_instruction_ret == LAST_PC) ? DONE : ISSUE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
    assign in_ready        = state == IDLE;
    assign out_valid       = state == DONE;
    assign busy            = state != IDLE;
    assign accept          = in_valid && in_ready;
    assign handoff         = out_valid && out_ready;
    assign exe_thread      = thr;
    assign exe_instruction = pc;
    assign out_thread      = thr;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            thr        <= '0;
            pc         <= '0;
            done_count <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                thr <= in_thread;
                pc  <= '0;
            end
            // the execute stage result is only meaningful in WAIT, one cycle after an ISSUE
            if (state == WAIT) begin
                thr <= exe_thread_ret;
                pc  <= exe_instruction_ret;
            end
            if (handoff) done_count <= done_count + DONE_CNT_W'(1);
        end
    end
`ifdef SEQ_CYCLE_COUNT_EN
    logic [15:0] cyc;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= '0;
        else        cyc <= accept ? '0 : (busy && cyc != 16'hFFFF) ? cyc + 16'd1 : cyc;
    end
    assign cycle_count = out_valid ? cyc : '0;
`endif
endmodule

// File: tb/tb_thread_sequencer.sv
// tb_thread_sequencer: randomized and directed self-checking bench for thread_sequencer
module tb_thread_sequencer;
    import my_pkg::*;
    localparam int P = 4;
    logic        clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
    logic        in_ready, out_valid, busy;
    thread_type  in_thread = '0, exe_thread, exe_thread_ret, out_thread;
    logic [7:0]  exe_instruction, exe_instruction_ret;
    logic [15:0] done_count, exp_done = 0;
    int          total = 0, bad = 0;
`ifdef SEQ_CYCLE_COUNT_EN
    logic [15:0] cycle_count;
`endif
    thread_sequencer #(.PROG_LEN(P), .DONE_CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_thread(in_thread),
        .exe_thread(exe_thread), .exe_instruction(exe_instruction), .exe_thread_ret(exe_thread_ret),
        .exe_instruction_ret(exe_instruction_ret), .out_valid(out_valid), .out_ready(out_ready),
        .out_thread(out_thread), .busy(busy), .done_count(done_count)
`ifdef SEQ_CYCLE_COUNT_EN
        , .cycle_count(cycle_count)
`endif
    );
    always #5 clk = ~clk;

    // execute stage stand-in: latches its inputs each edge, returns one executed instruction
    function automatic thread_type exec1(input thread_type t, input logic [7:0] pc);
        instr_type   i = t.code[pc[2:0]];
        logic [15:0] a = t.d[i.src_a], b = t.d[i.src_b];
        case (i.op)
            OP_ADD:  t.d[i.dst] = a + b;
            OP_SUB:  t.d[i.dst] = a - b;
            OP_MUL:  t.d[i.dst] = a * b;
            default: ;
        endcase
        return t;
    endfunction
    thread_type ex_thr = '0;
    logic [7:0] ex_pc = 0;
    always @(posedge clk) begin
        ex_thr <= exe_thread;
        ex_pc  <= exe_instruction;
    end
    assign exe_thread_ret      = exec1(ex_thr, ex_pc);
    assign exe_instruction_ret = ex_pc + 8'd1;

    // reference: whole program as plain integer arithmetic on a register array
    function automatic thread_type ref_run(input thread_type t);
        int unsigned r[8];
        thread_type  o = t;
        for (int i = 0; i < 8; i++) r[i] = t.d[i];
        for (int n = 0; n < P; n++) begin
            instr_type   c = t.code[n % 8];
            int unsigned a = r[c.src_a], b = r[c.src_b];
            if (c.op == OP_ADD) r[c.dst] = (a + b) & 32'hFFFF;
            if (c.op == OP_SUB) r[c.dst] = (a - b) & 32'hFFFF;
            if (c.op == OP_MUL) r[c.dst] = (a * b) & 32'hFFFF;
        end
        for (int i = 0; i < 8; i++) o.d[i] = 16'(r[i]);
        return o;
    endfunction

    function automatic thread_type rand_thread();
        thread_type t;
        for (int i = 0; i < 8; i++) begin
            t.code[i] = '{op_type'($urandom_range(0, 3)), 3'($urandom), 3'($urandom), 3'($urandom)};
            t.d[i]    = 16'($urandom);
        end
        return t;
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // called and returning at posedge+1; all sampling and driving happens at that point
    task automatic run(input thread_type t, input int stall, input bit hold_next,
                       input thread_type nxt, output int waited, output thread_type got);
        thread_type e = ref_run(t);
        int w = 0;
        in_thread = t;
        in_valid  = 1;
        while (!in_ready && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        chk("accept_ready", in_ready, 1);
        waited = w;
        @(posedge clk); #1;
        if (hold_next) in_thread = nxt;
        else in_valid = 0;
        for (int k = 0; k < 2 * P; k++) begin
            chk("run_no_out", out_valid, 0);
            chk("run_busy", busy, 1);
            if (k % 2 == 0) chk("issue_pc", exe_instruction, 8'(k / 2));
            if (k == 0) chk("issue_thread", exe_thread, t);
            @(posedge clk); #1;
        end
        for (int s = 0; s < stall; s++) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_thread", out_thread, e);
            @(posedge clk); #1;
        end
        out_ready = 1;
        chk("out_valid", out_valid, 1);
        chk("out_thread", out_thread, e);
`ifdef SEQ_CYCLE_COUNT_EN
        chk("cycle_count_hs", cycle_count, 16'(2 * P + stall));
`endif
        got = out_thread;
        @(posedge clk); #1;
        out_ready = 0;
        exp_done++;
        chk("done_count", done_count, exp_done);
        chk("post_idle", in_ready, 1);
        chk("post_no_out", out_valid, 0);
`ifdef SEQ_CYCLE_COUNT_EN
        chk("cycle_count_idle", cycle_count, 0);
`endif
    endtask

    initial begin
        thread_type t, t2, got;
        int w;
        // reset state, held and after release
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_done", done_count, 0);
        chk("rst_pc", exe_instruction, 0);
        chk("rst_exe_thread", exe_thread, '0);
        @(posedge clk); #1;
        rst_n = 1;
        repeat (3) begin @(posedge clk); #1; end
        chk("idle_busy", busy, 0);
        chk("idle_in_ready", in_ready, 1);
        chk("idle_done", done_count, 0);
        // directed program
        t = '0;
        t.code[0] = '{OP_ADD, 3'd2, 3'd0, 3'd1};
        t.code[1] = '{OP_MUL, 3'd3, 3'd2, 3'd2};
        t.code[2] = '{OP_SUB, 3'd4, 3'd3, 3'd1};
        t.code[3] = '{OP_ADD, 3'd5, 3'd4, 3'd0};
        t.d[0] = 16'd3;
        t.d[1] = 16'd5;
        run(t, 0, 0, '0, w, got);
        chk("d2", got.d[2], 8);
        chk("d3", got.d[3], 64);
        chk("d4", got.d[4], 59);
        chk("d5", got.d[5], 62);
        // backpressure with a competing input held, then back-to-back accept
        t  = rand_thread();
        t2 = rand_thread();
        run(t, 5, 1, t2, w, got);
        run(t2, 3, 0, '0, w, got);
        chk("b2b_accept_wait", w, 0);
        // reset pulse during the third WAIT
        t = rand_thread();
        in_thread = t;
        in_valid  = 1;
        @(posedge clk); #1;
        in_valid = 0;
        repeat (5) begin @(posedge clk); #1; end
        chk("pre_rst_busy", busy, 1);
        rst_n = 0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_out", out_valid, 0);
        chk("mid_rst_done", done_count, 0);
        chk("mid_rst_ready", in_ready, 1);
        @(posedge clk); #1;
        rst_n    = 1;
        exp_done = 0;
        run(t, 0, 0, '0, w, got);
        // randomized threads, stalls and held follow-ups
        t = rand_thread();
        for (int n = 0; n < 8; n++) begin
            bit h = 1'($urandom);
            t2 = rand_thread();
            run(t, $urandom_range(0, 3), h, t2, w, got);
            if (h) chk("rand_b2b_wait", w, 0);
            t = t2;
            if (!h) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
